// File: rtl/serial_subtractor_2bit_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_2bit_pkg
// Shared definitions for the bit-serial subtractor: FSM state encoding and a
// helper that sizes the bit counter.
// ---------------------------------------------------------------------------
package serial_subtractor_2bit_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } state_t;

   // Bit counter width: clog2(w), but never narrower than one bit.
   function automatic int cnt_width(input int w);
      if (w > 1) begin
         return $clog2(w);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/serial_subtractor_2bit_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_2bit_if
// Request/result bundle of the bit-serial subtractor.
//   start : request pulse, sampled when the block is not busy
//   x, y  : minuend / subtrahend (W bits), latched on an accepted start
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when z/b are valid
//   z, b  : difference x - y mod 2^W and borrow out
// master = requester side, slave = subtractor side.
// ---------------------------------------------------------------------------
interface serial_subtractor_2bit_if #(
   parameter int W = 2
);
   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         busy;
   logic         done;
   logic [W-1:0] z;
   logic         b;

   modport master (
      output start, x, y,
      input  busy, done, z, b
   );

   modport slave (
      input  start, x, y,
      output busy, done, z, b
   );
endinterface

// File: rtl/serial_subtractor_2bit_fs.sv
// ---------------------------------------------------------------------------
// full_subtractor_1bit
// Purely combinational one-bit full subtractor: a - bb - bin.
//   i_a    : minuend bit
//   i_bb   : subtrahend bit
//   i_bin  : borrow in
//   o_d    : difference bit
//   o_bout : borrow out
// ---------------------------------------------------------------------------
module full_subtractor_1bit (
   input  logic i_a,
   input  logic i_bb,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);
   assign o_d    = i_a ^ i_bb ^ i_bin;
   // Borrow when a=0,bb=1, or when a==bb and a borrow is already pending.
   assign o_bout = (~i_a & i_bb) | (~(i_a ^ i_bb) & i_bin);
endmodule

// File: rtl/serial_subtractor_2bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_2bit
// Bit-serial subtractor: z = x - y (mod 2^W) plus borrow flag. Operands are
// latched on an accepted start, then one bit per clock is pushed LSB first
// through a single full subtractor. Result appears W+1 cycles after the
// start edge as a one-cycle done pulse; z/b hold until the next start.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset (priority over start)
//   bus : slave side of serial_subtractor_2bit_if (start/x/y in,
//         busy/done/z/b out)
// ---------------------------------------------------------------------------
module serial_subtractor_2bit
   import serial_subtractor_2bit_pkg::*;
#(
   parameter int W = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   serial_subtractor_2bit_if.slave         bus
);

   localparam int            CW   = cnt_width(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t        r_state;
   logic [W-1:0]  r_xa;
   logic [W-1:0]  r_ya;
   logic [W-1:0]  r_z;
   logic          r_b;
   logic          r_borrow;
   logic [CW-1:0] r_count;
   logic          r_busy;
   logic          r_done;

   state_t        w_state_nxt;
   logic [W-1:0]  w_xa_nxt;
   logic [W-1:0]  w_ya_nxt;
   logic [W-1:0]  w_z_nxt;
   logic          w_b_nxt;
   logic          w_borrow_nxt;
   logic [CW-1:0] w_count_nxt;
   logic          w_d;
   logic          w_bout;

   full_subtractor_1bit u_fs (
      .i_a    (r_xa[0]),
      .i_bb   (r_ya[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   // Next-state and datapath update for the serial operation.
   always_comb begin
      w_state_nxt  = r_state;
      w_xa_nxt     = r_xa;
      w_ya_nxt     = r_ya;
      w_z_nxt      = r_z;
      w_b_nxt      = r_b;
      w_borrow_nxt = r_borrow;
      w_count_nxt  = r_count;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               // z and b are deliberately left alone; z is overwritten bitwise.
               w_state_nxt  = ST_RUN;
               w_xa_nxt     = bus.x;
               w_ya_nxt     = bus.y;
               w_borrow_nxt = 1'b0;
               w_count_nxt  = '0;
            end else begin
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Difference bit enters at the MSB so after W shifts bit 0 is at z[0].
            w_z_nxt        = r_z >> 1'b1;
            w_z_nxt[W-1]   = w_d;
            w_xa_nxt       = r_xa >> 1'b1;
            w_ya_nxt       = r_ya >> 1'b1;
            w_borrow_nxt   = w_bout;
            if (r_count == LAST) begin
               w_state_nxt = ST_DONE;
               w_b_nxt     = w_bout;
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count + CW'(1'b1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_xa     <= '0;
         r_ya     <= '0;
         r_z      <= '0;
         r_b      <= 1'b0;
         r_borrow <= 1'b0;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_xa     <= w_xa_nxt;
         r_ya     <= w_ya_nxt;
         r_z      <= w_z_nxt;
         r_b      <= w_b_nxt;
         r_borrow <= w_borrow_nxt;
         r_count  <= w_count_nxt;
         r_busy   <= (w_state_nxt == ST_RUN);
         r_done   <= (w_state_nxt == ST_DONE);
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.z    = r_z;
   assign bus.b    = r_b;

endmodule

// File: tb/tb_serial_subtractor_2bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_2bit
// Directed bench for the bit-serial subtractor: a W=2 instance and a W=8
// instance sharing clock and reset. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_2bit;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   serial_subtractor_2bit_if #(.W(2)) if2 ();
   serial_subtractor_2bit_if #(.W(8)) if8 ();

   serial_subtractor_2bit #(.W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2.slave)
   );

   serial_subtractor_2bit #(.W(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Start one W=2 operation at the current falling edge and wait for done.
   task automatic op2(input logic [1:0] xv, input logic [1:0] yv,
                      input logic [1:0] ez, input logic eb, input string tag);
      int cnt;
      if2.x     = xv;
      if2.y     = yv;
      if2.start = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) begin
            chk({tag, " busy"}, if2.busy, 1'b1);
            if2.start = 1'b0;
         end
      end while (!if2.done && cnt < 20);
      chk({tag, " latency"}, cnt, 3);
      chk({tag, " z"}, if2.z, ez);
      chk({tag, " b"}, if2.b, eb);
      chk({tag, " busy@done"}, if2.busy, 1'b0);
   endtask

   // Start one W=8 operation at the current falling edge and wait for done.
   task automatic op8(input logic [7:0] xv, input logic [7:0] yv,
                      input logic [7:0] ez, input logic eb, input string tag);
      int cnt;
      if8.x     = xv;
      if8.y     = yv;
      if8.start = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) begin
            if8.start = 1'b0;
         end
      end while (!if8.done && cnt < 40);
      chk({tag, " latency"}, cnt, 9);
      chk({tag, " z"}, if8.z, ez);
      chk({tag, " b"}, if8.b, eb);
   endtask

   initial begin
      rst       = 1'b1;
      if2.start = 1'b0;
      if2.x     = 2'd0;
      if2.y     = 2'd0;
      if8.start = 1'b0;
      if8.x     = 8'd0;
      if8.y     = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst busy", if2.busy, 1'b0);
      chk("rst done", if2.done, 1'b0);
      chk("rst z", if2.z, 2'd0);
      chk("rst b", if2.b, 1'b0);
      chk("rst8 busy", if8.busy, 1'b0);
      chk("rst8 z", if8.z, 8'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic case, then result hold once idle.
      op2(2'd3, 2'd1, 2'd2, 1'b0, "3-1");
      @(negedge clk);
      chk("hold done", if2.done, 1'b0);
      chk("hold busy", if2.busy, 1'b0);
      chk("hold z", if2.z, 2'd2);
      chk("hold b", if2.b, 1'b0);

      op2(2'd1, 2'd2, 2'd3, 1'b1, "1-2");
      op2(2'd0, 2'd0, 2'd0, 1'b0, "0-0");
      op2(2'd2, 2'd3, 2'd3, 1'b1, "2-3");

      // Exhaustive sweep, each start issued in the previous DONE cycle.
      for (int xi = 0; xi < 4; xi++) begin
         for (int yi = 0; yi < 4; yi++) begin
            op2(2'(xi), 2'(yi), 2'(xi - yi), (xi < yi), $sformatf("sweep %0d-%0d", xi, yi));
         end
      end
      @(negedge clk);

      // Start during RUN must be ignored.
      if2.x     = 2'd3;
      if2.y     = 2'd0;
      if2.start = 1'b1;
      @(negedge clk);
      if2.x     = 2'd0;
      if2.y     = 2'd3;
      @(negedge clk);
      if2.start = 1'b0;
      chk("ign busy", if2.busy, 1'b1);
      @(negedge clk);
      chk("ign done", if2.done, 1'b1);
      chk("ign z", if2.z, 2'd3);
      chk("ign b", if2.b, 1'b0);
      @(negedge clk);

      // Reset in the first RUN cycle aborts without a done pulse.
      if2.x     = 2'd2;
      if2.y     = 2'd1;
      if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", if2.busy, 1'b0);
      chk("abort done", if2.done, 1'b0);
      chk("abort z", if2.z, 2'd0);
      chk("abort b", if2.b, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort no done", if2.done, 1'b0);
      end
      op2(2'd2, 2'd1, 2'd1, 1'b0, "after abort");
      @(negedge clk);

      // Wider instance.
      op8(8'd200, 8'd55, 8'd145, 1'b0, "w8 200-55");
      op8(8'd55, 8'd200, 8'd111, 1'b1, "w8 55-200");
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
